// File: rtl/tft_buswr_funcmod_if.sv
// rtl/tft_buswr_funcmod_if.sv - call/done handshake between TFT controller and bus write engine
// Purpose: carries one write request from the TFT control module to the bus engine.
// Signals:
//   iCall  [2:0]  request: [2]=index+data, [1]=index only, [0]=data only
//   oDone         one-cycle completion pulse back to the controller
//   iAddr  [7:0]  register index
//   iData  [15:0] register or pixel data
// Modports: master = controller side, slave = bus engine side.
interface tft_buswr_funcmod_if;
  logic [2:0]  iCall;
  logic        oDone;
  logic [7:0]  iAddr;
  logic [15:0] iData;

  modport master (output iCall, output iAddr, output iData, input oDone);
  modport slave  (input iCall, input iAddr, input iData, output oDone);
endinterface

// File: rtl/tft_buswr_funcmod.sv
// rtl/tft_buswr_funcmod.sv - SSD1289 8080-style parallel bus write engine
// Purpose: turns controller calls into timed CS/RS/WR/DB strobes (index+data,
//          index-only or data-only writes) and pulses oDone when finished.
// Parameters: T_WRL / T_WRH = WR low / high time per phase in CLOCK cycles (1..255).
// Ports:
//   CLOCK   in   system clock, rising edge
//   RESET   in   synchronous active-high reset
//   bus     slave side of the call/done handshake (iCall, oDone, iAddr, iData)
//   TFT_CS  out  chip select, active low
//   TFT_RS  out  0 = index phase, 1 = data phase
//   TFT_WR  out  write strobe, active low (panel latches on rising edge)
//   TFT_RD  out  read strobe, tied high
//   TFT_DB  out  16-bit parallel data bus
module tft_buswr_funcmod #(
  parameter int T_WRL = 3,
  parameter int T_WRH = 3
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  tft_buswr_funcmod_if.slave   bus,
  output logic                 TFT_CS,
  output logic                 TFT_RS,
  output logic                 TFT_WR,
  output logic                 TFT_RD,
  output logic [15:0]          TFT_DB
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] IDX_LO = 3'd1;
  localparam logic [2:0] IDX_HI = 3'd2;
  localparam logic [2:0] DAT_LO = 3'd3;
  localparam logic [2:0] DAT_HI = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic [7:0] LOAD_L = 8'(T_WRL - 1);
  localparam logic [7:0] LOAD_H = 8'(T_WRH - 1);

  logic [2:0]  state;
  logic [7:0]  count;
  // Only "is there a data phase after the index phase" matters once accepted.
  logic        twoPhase;
  logic [15:0] dataReg;

  assign TFT_RD = 1'b1;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      count     <= 8'd0;
      twoPhase  <= 1'b0;
      dataReg   <= 16'h0000;
      TFT_CS    <= 1'b1;
      TFT_RS    <= 1'b1;
      TFT_WR    <= 1'b1;
      TFT_DB    <= 16'h0000;
      bus.oDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.oDone <= 1'b0;
          TFT_CS    <= 1'b1;
          TFT_WR    <= 1'b1;
          if (bus.iCall[2] || bus.iCall[1]) begin
            // Address goes straight onto DB; data is kept for a possible second phase.
            state    <= IDX_LO;
            twoPhase <= bus.iCall[2];
            dataReg  <= bus.iData;
            TFT_RS   <= 1'b0;
            TFT_DB   <= {8'h00, bus.iAddr};
            TFT_CS   <= 1'b0;
            TFT_WR   <= 1'b0;
            count    <= LOAD_L;
          end else if (bus.iCall[0]) begin
            state    <= DAT_LO;
            twoPhase <= 1'b0;
            dataReg  <= bus.iData;
            TFT_RS   <= 1'b1;
            TFT_DB   <= bus.iData;
            TFT_CS   <= 1'b0;
            TFT_WR   <= 1'b0;
            count    <= LOAD_L;
          end
        end
        IDX_LO: begin
          if (count == 8'd0) begin
            state  <= IDX_HI;
            TFT_WR <= 1'b1;
            count  <= LOAD_H;
          end else begin
            count <= count - 8'd1;
          end
        end
        IDX_HI: begin
          if (count == 8'd0) begin
            if (twoPhase) begin
              // CS stays low: the data phase follows the index phase directly.
              state  <= DAT_LO;
              TFT_RS <= 1'b1;
              TFT_DB <= dataReg;
              TFT_WR <= 1'b0;
              count  <= LOAD_L;
            end else begin
              state     <= DONE;
              TFT_CS    <= 1'b1;
              bus.oDone <= 1'b1;
            end
          end else begin
            count <= count - 8'd1;
          end
        end
        DAT_LO: begin
          if (count == 8'd0) begin
            state  <= DAT_HI;
            TFT_WR <= 1'b1;
            count  <= LOAD_H;
          end else begin
            count <= count - 8'd1;
          end
        end
        DAT_HI: begin
          if (count == 8'd0) begin
            state     <= DONE;
            TFT_CS    <= 1'b1;
            bus.oDone <= 1'b1;
          end else begin
            count <= count - 8'd1;
          end
        end
        DONE: begin
          // RS/DB keep their last values; oDone lasts exactly this one cycle.
          state     <= IDLE;
          bus.oDone <= 1'b0;
          TFT_CS    <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          bus.oDone <= 1'b0;
          TFT_CS    <= 1'b1;
          TFT_WR    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tft_buswr_funcmod.sv
// tb/tb_tft_buswr_funcmod.sv - self-checking bench for tft_buswr_funcmod
module tb_tft_buswr_funcmod;

  localparam int T_WRL = 3;
  localparam int T_WRH = 3;
  localparam int NPIX  = 2000;

  logic CLOCK;
  logic RESET;

  tft_buswr_funcmod_if busA ();
  tft_buswr_funcmod_if busB ();

  logic        csA, rsA, wrA, rdA;
  logic [15:0] dbA;
  logic        csB, rsB, wrB, rdB;
  logic [15:0] dbB;

  tft_buswr_funcmod #(.T_WRL(T_WRL), .T_WRH(T_WRH)) dutA (
    .CLOCK(CLOCK), .RESET(RESET), .bus(busA),
    .TFT_CS(csA), .TFT_RS(rsA), .TFT_WR(wrA), .TFT_RD(rdA), .TFT_DB(dbA)
  );

  tft_buswr_funcmod #(.T_WRL(1), .T_WRH(1)) dutB (
    .CLOCK(CLOCK), .RESET(RESET), .bus(busB),
    .TFT_CS(csB), .TFT_RS(rsB), .TFT_WR(wrB), .TFT_RD(rdB), .TFT_DB(dbB)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Expected WR phases as {RS, DB}, in the order the panel should latch them.
  logic [16:0] expQ[$];

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor for dutA: WR rising edges are popped against the scoreboard,
  // and WR low/high widths plus CS idle gaps are measured.
  logic prevWr, prevCs;
  int   lowCnt, highCnt, csHigh, wrRises;
  always @(negedge CLOCK) begin
    if (RESET) begin
      prevWr  = 1'b1;
      prevCs  = 1'b1;
      lowCnt  = 0;
      highCnt = 0;
      csHigh  = 0;
    end else begin
      if (!prevWr && wrA) begin
        wrRises++;
        check("wr_low_width", lowCnt, T_WRL);
        check("wr_pending", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) check("wr_phase_rs_db", {rsA, dbA}, expQ.pop_front());
        highCnt = 1;
      end else if (wrA && !csA) begin
        highCnt++;
      end
      if (prevWr && !wrA) begin
        if (!prevCs) check("wr_high_width_between", highCnt, T_WRH);
        lowCnt = 1;
      end else if (!wrA) begin
        lowCnt++;
      end
      if (!prevCs && csA) check("wr_high_width_last", highCnt, T_WRH);
      if (prevCs && !csA) check("cs_idle_gap", 32'(csHigh >= 1), 1);
      if (csA) csHigh++; else csHigh = 0;
      prevWr = wrA;
      prevCs = csA;
    end
  end

  task automatic doCall(input logic [2:0] c, input logic [7:0] a, input logic [15:0] d,
                        input int expLat, input bit chg, input logic [15:0] d2);
    int lat;
    bit done, csBad;
    @(negedge CLOCK);
    busA.iCall = c;
    busA.iAddr = a;
    busA.iData = d;
    if (c[2]) begin
      expQ.push_back({1'b0, 8'h00, a});
      expQ.push_back({1'b1, d});
    end else if (c[1]) begin
      expQ.push_back({1'b0, 8'h00, a});
    end else if (c[0]) begin
      expQ.push_back({1'b1, d});
    end
    @(posedge CLOCK);
    lat = 0; done = 0; csBad = 0;
    while (!done && lat < 100) begin
      @(negedge CLOCK);
      if (busA.oDone) begin
        done = 1;
      end else begin
        if (csA) csBad = 1;
        if (chg && lat == 4) begin
          busA.iData = d2;
          busA.iAddr = ~a;
        end
        @(posedge CLOCK);
        lat++;
      end
    end
    busA.iCall = 3'b000;
    check("done_seen", 32'(done), 1);
    check("done_latency", lat, expLat);
    check("cs_low_during_call", 32'(csBad), 0);
    @(negedge CLOCK);
    check("done_one_cycle", 32'(busA.oDone), 0);
    check("queue_drained", expQ.size(), 0);
  endtask

  int  latB, lowB, riseB, doneCnt, bound;
  bit  doneB, prevWrB, idleBad;

  initial begin
    busA.iCall = 3'b000; busA.iAddr = 8'h00; busA.iData = 16'h0000;
    busB.iCall = 3'b000; busB.iAddr = 8'h00; busB.iData = 16'h0000;
    wrRises = 0;
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    check("rst_cs", csA, 1);
    check("rst_rs", rsA, 1);
    check("rst_wr", wrA, 1);
    check("rst_rd", rdA, 1);
    check("rst_db", dbA, 16'h0000);
    check("rst_done", busA.oDone, 0);
    check("rstB_cs_wr", {csB, wrB, rdB, busB.oDone}, 4'b1110);
    RESET = 1'b0;

    // Reset mid IDX_LO abandons the cycle.
    @(negedge CLOCK);
    busA.iCall = 3'b100; busA.iAddr = 8'h55; busA.iData = 16'hAAAA;
    @(posedge CLOCK);
    @(negedge CLOCK);
    check("midrst_in_idx_lo", {csA, wrA, rsA}, 3'b000);
    RESET = 1'b1;
    busA.iCall = 3'b000;
    repeat (2) @(negedge CLOCK);
    check("midrst_cs", csA, 1);
    check("midrst_wr", wrA, 1);
    check("midrst_rs", rsA, 1);
    check("midrst_db", dbA, 16'h0000);
    check("midrst_done", busA.oDone, 0);
    RESET = 1'b0;
    idleBad = 0;
    repeat (5) begin
      @(negedge CLOCK);
      if (busA.oDone || !csA || !wrA) idleBad = 1;
    end
    check("midrst_stays_idle", 32'(idleBad), 0);

    // Two-phase register write, index-only, data-only.
    doCall(3'b100, 8'h11, 16'h6070, 2 * (T_WRL + T_WRH), 1'b0, 16'h0000);
    doCall(3'b010, 8'h22, 16'h9999, T_WRL + T_WRH, 1'b0, 16'h0000);
    doCall(3'b001, 8'h77, 16'hBEEF, T_WRL + T_WRH, 1'b0, 16'h0000);
    check("rs_db_hold_after_done", {rsA, dbA}, {1'b1, 16'hBEEF});

    // All bits set acts as index+data; input change after accept is ignored.
    doCall(3'b111, 8'h33, 16'hABCD, 2 * (T_WRL + T_WRH), 1'b1, 16'h1234);

    // Model controller streams pixels, holding iCall across back-to-back writes.
    wrRises = 0;
    @(negedge CLOCK);
    busA.iCall = 3'b001; busA.iData = 16'hFFFF;
    for (int i = 0; i < NPIX; i++) expQ.push_back({1'b1, 16'hFFFF});
    doneCnt = 0; bound = 0;
    while (doneCnt < NPIX && bound < NPIX * 12) begin
      @(negedge CLOCK);
      bound++;
      if (busA.oDone) begin
        doneCnt++;
        if (doneCnt == NPIX) busA.iCall = 3'b000;
      end
    end
    repeat (10) @(negedge CLOCK);
    check("stream_done_count", doneCnt, NPIX);
    check("stream_wr_rises", wrRises, NPIX);
    check("stream_queue_drained", expQ.size(), 0);
    check("stream_idle_after", {csA, wrA}, 2'b11);

    // Minimum timing build.
    @(negedge CLOCK);
    busB.iCall = 3'b100; busB.iAddr = 8'h44; busB.iData = 16'h5566;
    @(posedge CLOCK);
    latB = 0; lowB = 0; riseB = 0; doneB = 0; prevWrB = 1'b1;
    while (!doneB && latB < 50) begin
      @(negedge CLOCK);
      if (busB.oDone) begin
        doneB = 1;
      end else begin
        if (!wrB) lowB++;
        if (!prevWrB && wrB) riseB++;
        prevWrB = wrB;
        @(posedge CLOCK);
        latB++;
      end
    end
    busB.iCall = 3'b000;
    check("min_done_seen", 32'(doneB), 1);
    check("min_latency", latB, 4);
    check("min_wr_low_cycles", lowB, 2);
    check("min_wr_rises", riseB, 2);
    check("min_last_phase", {rsB, dbB}, {1'b1, 16'h5566});

    repeat (3) @(negedge CLOCK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
